// File: rtl/vector_pkg.sv
// vector_pkg: pixel layout and byte-lane constants for packed RGB streams
`include "common_defs.svh"
package vector_pkg;
  typedef struct packed {
    logic [`COLOR_WIDTH-1:0] r;
    logic [`COLOR_WIDTH-1:0] g;
    logic [`COLOR_WIDTH-1:0] b;
  } pixel_t;
  localparam int PIX_BYTES = 3;
  localparam int WORD_BYTES = 4;
  localparam int BUF_BYTES = 6;
endpackage

// File: rtl/common_defs.svh
`ifndef COMMON_DEFS_SVH
`define COMMON_DEFS_SVH
`define COLOR_WIDTH 8
`define SCREEN_WIDTH 640
`define SCREEN_HEIGHT 480
`endif

// File: rtl/frame_pos_counter.sv
// frame_pos_counter: x/y position counter with wrap at W-1 / H-1 and clear-then-advance
module frame_pos_counter #(
  parameter int W = 8,
  parameter int H = 2,
  parameter int XW = 10,
  parameter int YW = 9
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          clr,
  input  logic          inc,
  output logic [XW-1:0] x,
  output logic [YW-1:0] y
);
  logic [XW-1:0] bx, nx;
  logic [YW-1:0] by, ny;
  logic wrap;
  always_comb begin
    bx = clr ? '0 : x;
    by = clr ? '0 : y;
    wrap = bx == XW'(W - 1);
    nx = inc ? (wrap ? '0 : bx + 1'b1) : bx;
    ny = inc & wrap ? (by == YW'(H - 1) ? '0 : by + 1'b1) : by;
  end
  always_ff @(posedge clk) begin
    x <= rst ? '0 : nx;
    y <= rst ? '0 : ny;
  end
endmodule

// File: rtl/pixel_unpacker.sv
// pixel_unpacker: turns 32-bit packed RGB words (3 words = 4 pixels) into a pixel stream with framing checks
`include "common_defs.svh"
module pixel_unpacker
  import vector_pkg::*;
#(
  parameter int FRAME_W = `SCREEN_WIDTH,
  parameter int FRAME_H = `SCREEN_HEIGHT
) (
  input  logic                    out_stream_aclk,
  input  logic                    rst,
  input  logic [31:0]             in_stream_tdata,
  input  logic [3:0]              in_stream_tkeep,
  input  logic                    in_stream_tvalid,
  output logic                    in_stream_tready,
  input  logic                    in_stream_tlast,
  input  logic                    in_stream_tuser,
  output logic [`COLOR_WIDTH-1:0] r,
  output logic [`COLOR_WIDTH-1:0] g,
  output logic [`COLOR_WIDTH-1:0] b,
  output logic                    pix_valid,
  input  logic                    pix_ready,
  output logic                    pix_sof,
  output logic                    pix_eol,
  output logic [9:0]              pix_x,
  output logic [8:0]              pix_y,
  output logic                    err_sof,
  output logic                    err_eol,
  input  logic                    clr_err
);
  localparam int WPL = FRAME_W * 3 / 4;
  logic [47:0] bytes_q, shifted, bytes_d;
  logic [2:0] cnt, left, cnt_d;
  logic push, pop, resync, wsof, wlast, set_sof, set_eol, unused_keep;
  logic [9:0] wx;
  logic [8:0] wy;
  pixel_t pix;
  assign unused_keep = ^in_stream_tkeep;
  assign pix_valid = cnt >= 3'(PIX_BYTES);
  assign pop = pix_valid & pix_ready;
  assign in_stream_tready = !rst & ((cnt <= 3'(BUF_BYTES - WORD_BYTES)) | (pop & (cnt <= 3'(BUF_BYTES - 1))));
  assign push = in_stream_tvalid & in_stream_tready;
  assign wsof = wx == '0 && wy == '0;
  assign wlast = wx == 10'(WPL - 1);
  // a tuser word away from frame start restarts everything with this word as W0
  assign resync = push & in_stream_tuser & !wsof;
  assign set_sof = push & (in_stream_tuser != wsof);
  assign set_eol = push & (in_stream_tlast != (resync ? 1'b0 : wlast));
  assign pix = pixel_t'(bytes_q[23:0]);
  assign r = pix.r;
  assign g = pix.g;
  assign b = pix.b;
  assign pix_sof = pix_x == '0 && pix_y == '0;
  assign pix_eol = pix_x == 10'(FRAME_W - 1);
  always_comb begin
    shifted = pop ? bytes_q >> (8 * PIX_BYTES) : bytes_q;
    left = pop ? cnt - 3'(PIX_BYTES) : cnt;
    bytes_d = resync ? {16'b0, in_stream_tdata} : push ? shifted | ({16'b0, in_stream_tdata} << {left, 3'b000}) : shifted;
    cnt_d = resync ? 3'(WORD_BYTES) : push ? left + 3'(WORD_BYTES) : left;
  end
  always_ff @(posedge out_stream_aclk) begin
    bytes_q <= rst ? '0 : bytes_d;
    cnt <= rst ? '0 : cnt_d;
    err_sof <= rst ? 1'b0 : set_sof | (err_sof & !clr_err);
    err_eol <= rst ? 1'b0 : set_eol | (err_eol & !clr_err);
  end
  frame_pos_counter #(.W(FRAME_W), .H(FRAME_H), .XW(10), .YW(9)) u_pix_pos (
    .clk(out_stream_aclk), .rst(rst), .clr(resync), .inc(pop & !resync), .x(pix_x), .y(pix_y)
  );
  frame_pos_counter #(.W(WPL), .H(FRAME_H), .XW(10), .YW(9)) u_word_pos (
    .clk(out_stream_aclk), .rst(rst), .clr(resync), .inc(push), .x(wx), .y(wy)
  );
endmodule

// File: tb/tb_pixel_unpacker.sv
// tb_pixel_unpacker: byte-queue scoreboard bench for pixel_unpacker at FRAME_W=8, FRAME_H=2
module tb_pixel_unpacker;
  localparam int FW = 8, FH = 2, WPL = FW * 3 / 4;
  logic clk, rst, tvalid, tready, tlast, tuser, pix_valid, pix_ready, pix_sof, pix_eol;
  logic err_sof, err_eol, clr_err;
  logic [31:0] tdata;
  logic [3:0] tkeep;
  logic [7:0] r, g, b;
  logic [9:0] pix_x;
  logic [8:0] pix_y;
  typedef struct {
    logic [23:0] pix;
    int x;
    int y;
  } exp_t;
  exp_t eq[$];
  logic [7:0] mb[$];
  int mcnt, wi, wl, px, py, mode, passed, total;
  bit e_sof, e_eol;

  pixel_unpacker #(.FRAME_W(FW), .FRAME_H(FH)) dut (
    .out_stream_aclk(clk), .rst(rst), .in_stream_tdata(tdata), .in_stream_tkeep(tkeep),
    .in_stream_tvalid(tvalid), .in_stream_tready(tready), .in_stream_tlast(tlast),
    .in_stream_tuser(tuser), .r(r), .g(g), .b(b), .pix_valid(pix_valid), .pix_ready(pix_ready),
    .pix_sof(pix_sof), .pix_eol(pix_eol), .pix_x(pix_x), .pix_y(pix_y),
    .err_sof(err_sof), .err_eol(err_eol), .clr_err(clr_err)
  );

  initial begin
    clk = 0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got === exp) passed++;
    else $display("FAIL %s: got %h, expected %h at %0t", tag, got, exp, $time);
  endtask

  // model decisions at negedge mirror what the next posedge does
  always @(negedge clk) begin
    bit ns, ne, at0;
    ns = 0;
    ne = 0;
    if (rst) begin
      chk("tready_rst", tready, 0);
      mb.delete();
      eq.delete();
      {mcnt, wi, wl, px, py} = '0;
      e_sof = 0;
      e_eol = 0;
    end else begin
      chk("valid", pix_valid, mcnt >= 3);
      chk("err_sof", err_sof, e_sof);
      chk("err_eol", err_eol, e_eol);
      if (mcnt == 6) chk("tready_full", tready, 0);
      if (pix_valid) begin
        if (eq.size() == 0) chk("underflow", 1, 0);
        else begin
          chk("rgb", {r, g, b}, eq[0].pix);
          chk("x", pix_x, eq[0].x);
          chk("y", pix_y, eq[0].y);
          chk("sof", pix_sof, eq[0].x == 0 && eq[0].y == 0);
          chk("eol", pix_eol, eq[0].x == FW - 1);
        end
        if (pix_ready) begin
          if (eq.size() != 0) void'(eq.pop_front());
          mcnt -= 3;
        end
      end
      if (tvalid && tready) begin
        at0 = wi == 0 && wl == 0;
        if (tuser && !at0) begin
          mb.delete();
          eq.delete();
          {mcnt, wi, wl, px, py} = '0;
        end
        if (tuser != at0) ns = 1;
        if (tlast != (wi == WPL - 1)) ne = 1;
        for (int k = 0; k < 4; k++) mb.push_back(tdata[8*k+:8]);
        mcnt += 4;
        wi++;
        if (wi == WPL) begin
          wi = 0;
          wl = (wl + 1) % FH;
        end
        while (mb.size() >= 3) begin
          eq.push_back('{{mb[2], mb[1], mb[0]}, px, py});
          repeat (3) void'(mb.pop_front());
          px++;
          if (px == FW) begin
            px = 0;
            py = (py + 1) % FH;
          end
        end
      end
      e_sof = ns | (e_sof & !clr_err);
      e_eol = ne | (e_eol & !clr_err);
    end
  end

  initial begin
    pix_ready = 1;
    forever begin
      @(posedge clk);
      #1;
      pix_ready = mode == 0 ? 1'b1 : mode == 1 ? !pix_ready : 1'($urandom_range(0, 1));
    end
  end

  task automatic send_word(input logic [31:0] d, input logic l, input logic u);
    int n;
    tdata = d;
    tlast = l;
    tuser = u;
    tvalid = 1;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!tready && n < 100);
    if (!tready) chk("accept_timeout", 0, 1);
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] word_of(input int seed, input int i);
    logic [31:0] w;
    for (int k = 0; k < 4; k++) w[8*k+:8] = 8'(seed + 17 * (4 * i + k));
    return w;
  endfunction

  task automatic send_frame(input int seed, input int bad_last);
    for (int i = 0; i < 2 * WPL; i++)
      send_word(word_of(seed, i), i == bad_last || i % WPL == WPL - 1, i == 0);
    tvalid = 0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((eq.size() != 0 || mcnt != 0) && n < 300) begin
      @(negedge clk);
      n++;
    end
    chk("drain", eq.size(), 0);
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_clr();
    clr_err = 1;
    @(posedge clk);
    #1;
    clr_err = 0;
    @(negedge clk);
    chk("clr_sof", err_sof, 0);
    chk("clr_eol", err_eol, 0);
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected finish");
    $fatal(1);
  end

  initial begin
    passed = 0;
    total = 0;
    mode = 0;
    rst = 1;
    {tvalid, tlast, tuser, clr_err} = '0;
    tdata = 0;
    tkeep = 4'hf;
    repeat (3) @(posedge clk);
    #1;
    rst = 0;
    @(negedge clk);
    chk("rst_valid", pix_valid, 0);
    chk("rst_rgb", {r, g, b}, 0);
    chk("rst_err", {err_sof, err_eol}, 0);
    chk("rst_pos", {pix_y, pix_x}, 0);
    chk("rst_tready", tready, 1);
    @(posedge clk);
    #1;
    send_frame(0, -1);
    drain();
    chk("wrap_pos", {pix_y, pix_x}, 0);
    mode = 1;
    send_frame(5, -1);
    drain();
    mode = 0;
    send_frame(9, 3);
    drain();
    chk("eol_set", err_eol, 1);
    pulse_clr();
    for (int i = 0; i < 4; i++) send_word(word_of(20, i), 0, i == 0);
    send_frame(40, -1);
    drain();
    chk("sof_set", err_sof, 1);
    chk("sof_no_eol", err_eol, 0);
    pulse_clr();
    for (int i = 0; i < 2; i++) send_word(word_of(80, i), 0, i == 0);
    tvalid = 0;
    rst = 1;
    @(posedge clk);
    #1;
    rst = 0;
    @(negedge clk);
    chk("midrst_valid", pix_valid, 0);
    @(posedge clk);
    #1;
    mode = 2;
    send_frame(60, -1);
    drain();
    send_frame(100, -1);
    drain();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
